// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit: next-PC operations and trap causes.
package pc_pkg;

  typedef enum logic [2:0] {
    NPC_PLUS4  = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_JUMP   = 3'b010,
    NPC_JALR   = 3'b011,
    NPC_MRET   = 3'b100
  } npc_op_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_EXT      = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } cause_e;

endpackage

// File: rtl/pc_unit_npc_calc.sv
// Combinational next-PC candidate and misaligned-target detection.
module npc_calc
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [2:0]      npc_op,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] alu_c,
  input  logic [XLEN-1:0] epc,
  output logic [XLEN-1:0] npc,
  output logic            misalign
);

  logic [XLEN-1:0] br_off;
  logic [XLEN-1:0] jmp_off;
  logic            unused_bits;

  assign br_off      = {{(XLEN-13){imm[12]}}, imm[12:1], 1'b0};
  assign jmp_off     = {{(XLEN-21){imm[20]}}, imm[20:1], 1'b0};
  assign unused_bits = ^{imm[XLEN-1:21], imm[0], alu_c[0]};

  // Select the target; only control transfers computed from operands can be misaligned.
  always_comb begin
    npc      = pc + XLEN'(4);
    misalign = 1'b0;
    case (npc_op)
      NPC_BRANCH: begin
        npc      = pc + br_off;
        misalign = npc[1];
      end
      NPC_JUMP: begin
        npc      = pc + jmp_off;
        misalign = npc[1];
      end
      NPC_JALR: begin
        npc      = {alu_c[XLEN-1:1], 1'b0};
        misalign = npc[1];
      end
      NPC_MRET: begin
        npc = epc;
      end
      default: begin
        npc = pc + XLEN'(4);
      end
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// PC register with trap/stall priority, saved exception PC, cause and retired-instruction counter.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100,
  parameter int              CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       npc_op,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  alu_c,
  input  logic             trap_req,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  npc,
  output logic [XLEN-1:0]  epc,
  output logic [1:0]       cause,
  output logic             trap_taken,
  output logic [CNT_W-1:0] instret
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  epc_q, epc_d;
  logic [1:0]       cause_q, cause_d;
  logic             trap_taken_q, trap_taken_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             misalign;

  npc_calc #(.XLEN(XLEN)) u_npc_calc (
    .pc       (pc_q),
    .npc_op   (npc_op),
    .imm      (imm),
    .alu_c    (alu_c),
    .epc      (epc_q),
    .npc      (npc),
    .misalign (misalign)
  );

  // Next-state priority: external trap, then misaligned target, then stall, then normal retire.
  always_comb begin
    pc_d         = pc_q;
    epc_d        = epc_q;
    cause_d      = cause_q;
    trap_taken_d = 1'b0;
    instret_d    = instret_q;
    if (trap_req) begin
      pc_d         = TRAP_VEC;
      epc_d        = pc_q;
      cause_d      = CAUSE_EXT;
      trap_taken_d = 1'b1;
    end else if (misalign && !stall) begin
      pc_d         = TRAP_VEC;
      epc_d        = pc_q;
      cause_d      = CAUSE_MISALIGN;
      trap_taken_d = 1'b1;
    end else if (!stall) begin
      pc_d      = npc;
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset taking precedence over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_VEC;
      epc_q        <= '0;
      cause_q      <= CAUSE_NONE;
      trap_taken_q <= 1'b0;
      instret_q    <= '0;
    end else begin
      pc_q         <= pc_d;
      epc_q        <= epc_d;
      cause_q      <= cause_d;
      trap_taken_q <= trap_taken_d;
      instret_q    <= instret_d;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign cause      = cause_q;
  assign trap_taken = trap_taken_q;
  assign instret    = instret_q;

endmodule
